// File: rtl/mantissa_normalizer.sv
// rtl/mantissa_normalizer.sv - sequential left-shift significand normalizer
// Shifts one bit per cycle until the hidden bit is set, stopping on zero or exponent floor.
module mantissa_normalizer #(
    parameter int MANT_W = 24,
    parameter int EXP_W  = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [MANT_W-1:0] mant_in,
    input  logic [EXP_W-1:0]  exp_in,
    output logic              busy,
    output logic              done,
    output logic [MANT_W-1:0] mant_out,
    output logic [EXP_W-1:0]  exp_out,
    output logic [CNT_W-1:0]  shift_cnt,
    output logic              zero,
    output logic              denorm
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q;
    logic [MANT_W-1:0]  mant_q;
    logic [EXP_W-1:0]   exp_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               zero_q;
    logic               denorm_q;
    logic               busy_q;
    logic               done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            mant_q   <= '0;
            exp_q    <= '0;
            cnt_q    <= '0;
            zero_q   <= 1'b0;
            denorm_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            // Status flags trail the state by one cycle so they come straight off flops.
            busy_q <= (state_q != IDLE);
            done_q <= (state_q == DONE);

            case (state_q)
                IDLE: begin
                    if (start) begin
                        mant_q   <= mant_in;
                        exp_q    <= exp_in;
                        cnt_q    <= '0;
                        zero_q   <= 1'b0;
                        denorm_q <= 1'b0;
                        state_q  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (mant_q == '0) begin
                        zero_q  <= 1'b1;
                        exp_q   <= '0;
                        state_q <= DONE;
                    end else if (mant_q[MANT_W-1]) begin
                        state_q <= DONE;
                    end else if (exp_q <= EXP_W'(1)) begin
                        // Exponent floor: leave the significand as a denormal.
                        denorm_q <= 1'b1;
                        exp_q    <= '0;
                        state_q  <= DONE;
                    end else begin
                        mant_q <= {mant_q[MANT_W-2:0], 1'b0};
                        exp_q  <= exp_q - EXP_W'(1);
                        cnt_q  <= cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign mant_out  = mant_q;
    assign exp_out   = exp_q;
    assign shift_cnt = cnt_q;
    assign zero      = zero_q;
    assign denorm    = denorm_q;

endmodule

// File: tb/tb_mantissa_normalizer.sv
// tb/tb_mantissa_normalizer.sv - self-checking bench for mantissa_normalizer
module tb_mantissa_normalizer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [23:0] mant_in;
    logic [7:0]  exp_in;
    logic        busy;
    logic        done;
    logic [23:0] mant_out;
    logic [7:0]  exp_out;
    logic [7:0]  shift_cnt;
    logic        zero;
    logic        denorm;

    int passed = 0;
    int total  = 0;

    mantissa_normalizer #(.MANT_W(24), .EXP_W(8), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mant_in   (mant_in),
        .exp_in    (exp_in),
        .busy      (busy),
        .done      (done),
        .mant_out  (mant_out),
        .exp_out   (exp_out),
        .shift_cnt (shift_cnt),
        .zero      (zero),
        .denorm    (denorm)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] m;
        logic [7:0]  e;
        logic [23:0] em;
        logic [7:0]  ee;
        int          ec;
        logic        ez;
        logic        ed;
    } vec_t;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, req, req);
    endtask

    // Reference: count leading zeros, then shift as far as the exponent allows.
    task automatic model(input logic [23:0] m, input logic [7:0] e, output logic [23:0] em,
                         output logic [7:0] ee, output int ec, output logic ez, output logic ed);
        int lz = 24;
        int ei = int'(e);
        for (int i = 23; i >= 0; i--)
            if (m[i] && lz == 24) lz = 23 - i;
        ez = 1'b0; ed = 1'b0;
        if (m == 24'd0) begin
            em = 24'd0; ee = 8'd0; ec = 0; ez = 1'b1;
        end else if (lz == 0) begin
            em = m; ee = e; ec = 0;
        end else if (lz <= ei - 1) begin
            em = m << lz; ee = 8'(ei - lz); ec = lz;
        end else begin
            ec = (ei > 1) ? ei - 1 : 0;
            em = m << ec; ee = 8'd0; ed = 1'b1;
        end
    endtask

    task automatic run_op(input string tag, input vec_t v);
        int lat = 0;
        logic [23:0] held;
        start = 1'b1; mant_in = v.m; exp_in = v.e;
        @(posedge clk); #1;
        start = 1'b0; mant_in = 24'($urandom()); exp_in = 8'($urandom());
        for (int c = 1; c <= 40 && lat == 0; c++) begin
            @(posedge clk); #1;
            if (c == 1) check({tag, " busy_early"}, int'(busy), 1);
            if (done) lat = c;
        end
        check({tag, " latency"}, lat, v.ec + 2);
        check({tag, " mant_out"}, int'(mant_out), int'(v.em));
        check({tag, " exp_out"}, int'(exp_out), int'(v.ee));
        check({tag, " shift_cnt"}, int'(shift_cnt), v.ec);
        check({tag, " zero"}, int'(zero), int'(v.ez));
        check({tag, " denorm"}, int'(denorm), int'(v.ed));
        check({tag, " busy_in_done"}, int'(busy), 1);
        held = mant_out;
        @(posedge clk); #1;
        check({tag, " done_pulse"}, int'(done), 0);
        check({tag, " busy_after"}, int'(busy), 0);
        check({tag, " mant_held"}, int'(mant_out), int'(held));
    endtask

    vec_t tbl[10];

    initial begin
        vec_t v;
        int saw_done;
        rst = 1'b1; start = 1'b0; mant_in = '0; exp_in = '0;

        tbl[0] = '{24'h400000, 8'd10,  24'h800000, 8'd9,   1,  1'b0, 1'b0};
        tbl[1] = '{24'h800000, 8'd127, 24'h800000, 8'd127, 0,  1'b0, 1'b0};
        tbl[2] = '{24'h000001, 8'd100, 24'h800000, 8'd77,  23, 1'b0, 1'b0};
        tbl[3] = '{24'h000010, 8'd3,   24'h000040, 8'd0,   2,  1'b0, 1'b1};
        tbl[4] = '{24'h000000, 8'd50,  24'h000000, 8'd0,   0,  1'b1, 1'b0};
        tbl[5] = '{24'h800000, 8'd0,   24'h800000, 8'd0,   0,  1'b0, 1'b0};
        tbl[6] = '{24'h000100, 8'd0,   24'h000100, 8'd0,   0,  1'b0, 1'b1};
        tbl[7] = '{24'h000100, 8'd1,   24'h000100, 8'd0,   0,  1'b0, 1'b1};
        tbl[8] = '{24'h0FFFFF, 8'd5,   24'hFFFFF0, 8'd1,   4,  1'b0, 1'b0};
        tbl[9] = '{24'h0FFFFF, 8'd4,   24'h7FFFF8, 8'd0,   3,  1'b0, 1'b1};

        repeat (2) @(posedge clk);
        #1;
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset mant_out", int'(mant_out), 0);
        check("reset exp_out", int'(exp_out), 0);
        check("reset shift_cnt", int'(shift_cnt), 0);
        check("reset zero", int'(zero), 0);
        check("reset denorm", int'(denorm), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) run_op($sformatf("vec%0d", i), tbl[i]);

        for (int i = 0; i < 40; i++) begin
            v.m = 24'($urandom()) >> $urandom_range(0, 24);
            v.e = (i % 2 == 0) ? 8'($urandom_range(0, 30)) : 8'($urandom_range(0, 255));
            model(v.m, v.e, v.em, v.ee, v.ec, v.ez, v.ed);
            run_op($sformatf("rnd%0d", i), v);
        end

        // Abort mid-shift, with an ignored start in between.
        saw_done = 0;
        start = 1'b1; mant_in = 24'h000001; exp_in = 8'd100;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            if (c == 5) begin start = 1'b1; mant_in = 24'h800000; exp_in = 8'd5; end
            @(posedge clk); #1;
            start = 1'b0;
            if (done) saw_done = 1;
        end
        check("abort ignored_start cnt", int'(shift_cnt), 9);
        check("abort ignored_start exp", int'(exp_out), 91);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        if (done) saw_done = 1;
        check("abort busy", int'(busy), 0);
        check("abort mant_out", int'(mant_out), 0);
        check("abort exp_out", int'(exp_out), 0);
        check("abort shift_cnt", int'(shift_cnt), 0);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (done || busy) saw_done = 1;
        end
        check("abort no_done", saw_done, 0);
        run_op("after_abort", tbl[0]);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
